// File: rtl/rle_index_seeker_pkg.sv
// rtl/rle_index_seeker_pkg.sv - shared decoder state encodings and snapshot field layout
package rle_index_seeker_pkg;

  typedef enum logic [1:0] {
    ST_FIRST = 2'b00,
    ST_LIT   = 2'b01,
    ST_RUN   = 2'b10
  } state_e;

  // Snapshot layout, LSB first: {run_value, last_sample, state}
  localparam int SNAP_STATE_LSB = 0;
  localparam int SNAP_STATE_W   = 2;
  localparam int SNAP_LAST_LSB  = SNAP_STATE_LSB + SNAP_STATE_W;

  function automatic int snap_run_lsb(input int sample_w);
    return SNAP_LAST_LSB + sample_w;
  endfunction

  function automatic int snap_width(input int sample_w);
    return 2 * sample_w + SNAP_STATE_W;
  endfunction

endpackage

// File: rtl/rle_index_seeker_span_check.sv
// rtl/rle_index_seeker_span_check.sv - tests whether a word's decoded span covers the seek target
module rle_span_check #(
  parameter int SAMPLE_W = 16,
  parameter int INDEX_W  = 60
) (
  input  logic [INDEX_W-1:0]  index_old,
  input  logic [INDEX_W-1:0]  index_new,
  input  logic [INDEX_W-1:0]  target,
  input  logic                is_run,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] run_value,
  output logic                hit,
  output logic [SAMPLE_W-1:0] value
);

  logic [INDEX_W-1:0] offset;
  logic [INDEX_W-1:0] span_len;

  // Offset/length form equals index_old <= target < index_new and stays correct across index wrap.
  assign offset   = target - index_old;
  assign span_len = index_new - index_old;
  assign hit      = (offset < span_len);
  assign value    = is_run ? run_value : sample;

endmodule

// File: rtl/rle_index_seeker.sv
// rtl/rle_index_seeker.sv - RLE stream decoder tracking decoded index, with seek-to-index and state snapshot
module rle_index_seeker
  import rle_index_seeker_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int INDEX_W  = 60,
  parameter int WORD_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [SAMPLE_W-1:0]   sample,
  input  logic                  sample_strobe,
  output logic [INDEX_W-1:0]    index,
  output logic [WORD_W-1:0]     word_count,
  input  logic [INDEX_W-1:0]    seek_target,
  input  logic                  seek_start,
  output logic                  seek_busy,
  output logic                  seek_done,
  output logic                  seek_miss,
  output logic [SAMPLE_W-1:0]   seek_sample,
  output logic [WORD_W-1:0]     seek_word,
  output logic [2*SAMPLE_W+1:0] state_out,
  input  logic                  state_load,
  input  logic [2*SAMPLE_W+1:0] state_in
);

  localparam int RUN_LSB = snap_run_lsb(SAMPLE_W);

  logic [INDEX_W-1:0]  index_q, index_d;
  logic [WORD_W-1:0]   word_count_q, word_count_d;
  logic [1:0]          state_q, state_d;
  logic [SAMPLE_W-1:0] last_sample_q, last_sample_d;
  logic [SAMPLE_W-1:0] run_value_q, run_value_d;
  logic [INDEX_W-1:0]  seek_target_q, seek_target_d;
  logic                seek_busy_q, seek_busy_d;
  logic                seek_done_q, seek_done_d;
  logic                seek_miss_q, seek_miss_d;
  logic [SAMPLE_W-1:0] seek_sample_q, seek_sample_d;
  logic [WORD_W-1:0]   seek_word_q, seek_word_d;

  logic                is_run;
  logic [INDEX_W-1:0]  step_inc;
  logic [INDEX_W-1:0]  index_next;
  logic                decode_en;
  logic [INDEX_W-1:0]  span_target;
  logic                span_hit;
  logic [SAMPLE_W-1:0] span_value;
  logic                already_passed;

  assign is_run         = (state_q == ST_RUN);
  assign step_inc       = is_run ? INDEX_W'(sample) : INDEX_W'(1);
  assign index_next     = index_q + step_inc;
  assign decode_en      = sample_strobe && !state_load;
  assign span_target    = seek_start ? seek_target : seek_target_q;
  assign already_passed = (seek_target < index_q);

  rle_span_check #(
    .SAMPLE_W (SAMPLE_W),
    .INDEX_W  (INDEX_W)
  ) u_span_check (
    .index_old (index_q),
    .index_new (index_next),
    .target    (span_target),
    .is_run    (is_run),
    .sample    (sample),
    .run_value (run_value_q),
    .hit       (span_hit),
    .value     (span_value)
  );

  always_comb begin
    index_d       = index_q;
    word_count_d  = word_count_q;
    state_d       = state_q;
    last_sample_d = last_sample_q;
    run_value_d   = run_value_q;
    seek_target_d = seek_target_q;
    seek_busy_d   = seek_busy_q;
    seek_done_d   = 1'b0;
    seek_miss_d   = seek_miss_q;
    seek_sample_d = seek_sample_q;
    seek_word_d   = seek_word_q;

    if (clear) begin
      index_d      = '0;
      word_count_d = '0;
      state_d      = ST_FIRST;
      seek_busy_d  = 1'b0;
      seek_miss_d  = 1'b0;
    end else begin
      if (state_load) begin
        state_d       = state_in[SNAP_STATE_LSB +: SNAP_STATE_W];
        last_sample_d = state_in[SNAP_LAST_LSB +: SAMPLE_W];
        run_value_d   = state_in[RUN_LSB +: SAMPLE_W];
      end else if (sample_strobe) begin
        word_count_d = word_count_q + WORD_W'(1);
        index_d      = index_next;
        case (state_q)
          ST_LIT: begin
            last_sample_d = sample;
            if (sample == last_sample_q) begin
              run_value_d = sample;
              state_d     = ST_RUN;
            end else begin
              state_d = ST_LIT;
            end
          end
          ST_RUN: begin
            state_d = (&sample) ? ST_RUN : ST_FIRST;
          end
          default: begin
            last_sample_d = sample;
            state_d       = ST_LIT;
          end
        endcase
      end

      // A fresh arm is checked against the word strobed in the same cycle.
      if (seek_start) begin
        seek_target_d = seek_target;
        seek_busy_d   = 1'b1;
        seek_miss_d   = 1'b0;
        if (decode_en && span_hit) begin
          seek_busy_d   = 1'b0;
          seek_done_d   = 1'b1;
          seek_sample_d = span_value;
          seek_word_d   = word_count_q;
        end else if (already_passed) begin
          seek_busy_d = 1'b0;
          seek_done_d = 1'b1;
          seek_miss_d = 1'b1;
        end
      end else if (seek_busy_q && decode_en && span_hit) begin
        seek_busy_d   = 1'b0;
        seek_done_d   = 1'b1;
        seek_sample_d = span_value;
        seek_word_d   = word_count_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q       <= '0;
      word_count_q  <= '0;
      state_q       <= ST_FIRST;
      last_sample_q <= '0;
      run_value_q   <= '0;
      seek_target_q <= '0;
      seek_busy_q   <= 1'b0;
      seek_done_q   <= 1'b0;
      seek_miss_q   <= 1'b0;
      seek_sample_q <= '0;
      seek_word_q   <= '0;
    end else begin
      index_q       <= index_d;
      word_count_q  <= word_count_d;
      state_q       <= state_d;
      last_sample_q <= last_sample_d;
      run_value_q   <= run_value_d;
      seek_target_q <= seek_target_d;
      seek_busy_q   <= seek_busy_d;
      seek_done_q   <= seek_done_d;
      seek_miss_q   <= seek_miss_d;
      seek_sample_q <= seek_sample_d;
      seek_word_q   <= seek_word_d;
    end
  end

  assign index       = index_q;
  assign word_count  = word_count_q;
  assign seek_busy   = seek_busy_q;
  assign seek_done   = seek_done_q;
  assign seek_miss   = seek_miss_q;
  assign seek_sample = seek_sample_q;
  assign seek_word   = seek_word_q;
  assign state_out   = {run_value_q, last_sample_q, state_q};

endmodule

// File: tb/tb_rle_index_seeker.sv
// tb/tb_rle_index_seeker.sv - scoreboard bench for rle_index_seeker against a span-based reference model
module tb_rle_index_seeker;

  localparam int SW  = 16;
  localparam int IW  = 60;
  localparam int WW  = 32;
  localparam int SNW = 2 * SW + 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear = 1'b0;
  logic [SW-1:0]  sample = '0;
  logic           sample_strobe = 1'b0;
  logic [IW-1:0]  index;
  logic [WW-1:0]  word_count;
  logic [IW-1:0]  seek_target = '0;
  logic           seek_start = 1'b0;
  logic           seek_busy;
  logic           seek_done;
  logic           seek_miss;
  logic [SW-1:0]  seek_sample;
  logic [WW-1:0]  seek_word;
  logic [SNW-1:0] state_out;
  logic           state_load = 1'b0;
  logic [SNW-1:0] state_in = '0;

  rle_index_seeker #(.SAMPLE_W(SW), .INDEX_W(IW), .WORD_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .sample(sample), .sample_strobe(sample_strobe),
    .index(index), .word_count(word_count), .seek_target(seek_target), .seek_start(seek_start),
    .seek_busy(seek_busy), .seek_done(seek_done), .seek_miss(seek_miss), .seek_sample(seek_sample),
    .seek_word(seek_word), .state_out(state_out), .state_load(state_load), .state_in(state_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int             tag;
    logic [IW-1:0]  idx;
    logic [WW-1:0]  wc;
    logic [SNW-1:0] snap;
    logic           busy;
    logic           done;
    logic           miss;
    logic [SW-1:0]  smp;
    logic [WW-1:0]  wrd;
  } st_exp_t;

  typedef struct {
    logic          miss;
    logic [SW-1:0] smp;
    logic [WW-1:0] wrd;
  } seek_exp_t;

  st_exp_t   st_q[$];
  seek_exp_t sk_q[$];

  // Reference model: decoded position and the span each word covers.
  logic [IW-1:0] m_idx, m_tgt;
  logic [WW-1:0] m_wc, m_wrd;
  logic [1:0]    m_mode;
  logic [SW-1:0] m_last, m_runv, m_smp;
  logic          m_armed, m_miss;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = '0; m_tgt = '0; m_wc = '0; m_wrd = '0; m_mode = 2'd0;
    m_last = '0; m_runv = '0; m_smp = '0; m_armed = 1'b0; m_miss = 1'b0;
  endtask

  task automatic model_step(input bit strb, input logic [SW-1:0] s, input bit start,
                            input logic [IW-1:0] t, input bit clr, input bit ld,
                            input logic [SNW-1:0] lv, output bit done);
    logic [IW-1:0] lo, hi, t_eff;
    logic [SW-1:0] dval;
    logic [WW-1:0] wold;
    bit eff, in_span;
    done = 0;
    if (clr) begin
      m_idx = '0; m_wc = '0; m_mode = 2'd0; m_armed = 1'b0; m_miss = 1'b0;
      return;
    end
    eff  = strb && !ld;
    lo   = m_idx;
    wold = m_wc;
    if (m_mode == 2'd2) begin hi = lo + IW'(s); dval = m_runv; end
    else begin hi = lo + 1; dval = s; end
    t_eff   = start ? t : m_tgt;
    in_span = eff && (t_eff >= lo) && (t_eff < hi);
    if (ld) begin
      m_mode = lv[1:0]; m_last = lv[SW+1:2]; m_runv = lv[2*SW+1:SW+2];
    end else if (strb) begin
      m_wc = m_wc + 1;
      m_idx = hi;
      case (m_mode)
        2'd2: m_mode = (s == {SW{1'b1}}) ? 2'd2 : 2'd0;
        2'd1: begin
          if (s == m_last) begin m_runv = s; m_mode = 2'd2; end
          m_last = s;
        end
        default: begin m_last = s; m_mode = 2'd1; end
      endcase
    end
    if (start) begin m_tgt = t; m_armed = 1'b1; m_miss = 1'b0; end
    if (m_armed) begin
      if (in_span) begin
        done = 1; m_armed = 1'b0; m_smp = dval; m_wrd = wold;
        sk_q.push_back('{miss: 1'b0, smp: dval, wrd: wold});
      end else if (start && t < lo) begin
        done = 1; m_armed = 1'b0; m_miss = 1'b1;
        sk_q.push_back('{miss: 1'b1, smp: m_smp, wrd: m_wrd});
      end
    end
  endtask

  task automatic step(input bit strb, input logic [SW-1:0] s, input bit start = 0,
                      input logic [IW-1:0] t = '0, input bit clr = 0, input bit ld = 0,
                      input logic [SNW-1:0] lv = '0);
    bit done;
    sample_strobe = strb; sample = s; seek_start = start; seek_target = t;
    clear = clr; state_load = ld; state_in = lv;
    model_step(strb, s, start, t, clr, ld, lv, done);
    st_q.push_back('{tag: cyc, idx: m_idx, wc: m_wc, snap: {m_runv, m_last, m_mode},
                     busy: m_armed, done: done, miss: m_miss, smp: m_smp, wrd: m_wrd});
    @(posedge clk);
    #1;
    sample_strobe = 0; seek_start = 0; clear = 0; state_load = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    st_q.delete();
    sk_q.delete();
    #2;
    chk("rst_index", 64'(index), 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    chk("rst_state_out", 64'(state_out), 64'd0);
    chk("rst_busy_done_miss", {61'd0, seek_busy, seek_done, seek_miss}, 64'd0);
    chk("rst_seek_sample", 64'(seek_sample), 64'd0);
    chk("rst_seek_word", 64'(seek_word), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: matures expectations one edge after issue and scores every seek_done pulse.
  st_exp_t e;
  seek_exp_t r;
  always @(negedge clk) begin
    if (rst_n) begin
      while (st_q.size() > 0 && st_q[0].tag < cyc) begin
        e = st_q.pop_front();
        chk("index", 64'(index), 64'(e.idx));
        chk("word_count", 64'(word_count), 64'(e.wc));
        chk("state_out", 64'(state_out), 64'(e.snap));
        chk("seek_busy", 64'(seek_busy), 64'(e.busy));
        chk("seek_done", 64'(seek_done), 64'(e.done));
        chk("seek_miss", 64'(seek_miss), 64'(e.miss));
        chk("seek_sample", 64'(seek_sample), 64'(e.smp));
        chk("seek_word", 64'(seek_word), 64'(e.wrd));
      end
      if (seek_done) begin
        if (sk_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL seek_unexpected actual=1 required=0");
        end else begin
          r = sk_q.pop_front();
          chk("sb_miss", 64'(seek_miss), 64'(r.miss));
          chk("sb_sample", 64'(seek_sample), 64'(r.smp));
          chk("sb_word", 64'(seek_word), 64'(r.wrd));
        end
      end
    end
  end

  logic [SNW-1:0] snap;
  logic [IW-1:0]  tgt;
  logic [SW-1:0]  sv;

  initial begin
    model_reset();
    do_reset();
    step(0, '0);

    // Three distinct literals
    step(1, 16'h000A); step(1, 16'h000B); step(1, 16'h000C);
    chk("r025_index", 64'(index), 64'd3);
    chk("r025_wc", 64'(word_count), 64'd3);
    chk("r025_state", 64'(state_out[1:0]), 64'd1);

    // Literal pair, max run continuation, short run with seek inside the long run
    step(0, '0, 0, '0, 1);
    step(0, '0, 1, IW'(40000));
    step(1, 16'd5); step(1, 16'd5);
    chk("r026_index2", 64'(index), 64'd2);
    step(1, 16'hFFFF);
    chk("r026_index3", 64'(index), 64'h10001);
    chk("r027_done", 64'(seek_done), 64'd1);
    chk("r027_sample", 64'(seek_sample), 64'd5);
    chk("r027_word", 64'(seek_word), 64'd2);
    step(1, 16'd3);
    chk("r026_index4", 64'(index), 64'h10004);
    chk("r026_state", 64'(state_out[1:0]), 64'd0);
    chk("r026_runv", 64'(state_out[SNW-1:SW+2]), 64'd5);
    chk("r027_pulse", 64'(seek_done), 64'd0);

    // Target already passed
    step(0, '0, 0, '0, 1);
    for (int i = 0; i < 10; i++) step(1, (i % 2 == 0) ? 16'd1 : 16'd2);
    step(0, '0, 1, IW'(4));
    chk("r028_done", 64'(seek_done), 64'd1);
    chk("r028_miss", 64'(seek_miss), 64'd1);
    chk("r028_busy", 64'(seek_busy), 64'd0);

    // Snapshot restore after clear
    step(0, '0, 0, '0, 1);
    step(1, 16'd7); step(1, 16'd7);
    snap = state_out;
    step(0, '0, 0, '0, 1);
    step(0, '0, 0, '0, 0, 1, snap);
    step(1, 16'd2);
    chk("r029_index", 64'(index), 64'd2);
    chk("r029_state", 64'(state_out[1:0]), 64'd0);

    // Reset during an armed seek
    step(0, '0, 0, '0, 1);
    step(1, 16'd1, 1, IW'(5));
    chk("r030_busy", 64'(seek_busy), 64'd1);
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 16'd9 + 16'(i));

    // Randomised traffic
    for (int n = 0; n < 800; n++) begin
      int rr, pick;
      bit clr, ld, start;
      rr = $urandom_range(0, 99);
      clr = (rr < 3);
      ld = (rr >= 3 && rr < 6);
      start = ($urandom_range(0, 7) == 0);
      if (m_idx > 20 && $urandom_range(0, 3) == 0) tgt = m_idx - IW'($urandom_range(1, 20));
      else tgt = m_idx + IW'($urandom_range(0, 30));
      pick = $urandom_range(0, 6);
      case (pick)
        0: sv = 16'd0;
        1: sv = 16'hFFFF;
        2, 3: sv = 16'd1;
        4: sv = 16'd2;
        default: sv = 16'($urandom_range(0, 40));
      endcase
      step($urandom_range(0, 3) != 0, sv, start, tgt, clr, ld, SNW'({$urandom(), $urandom()}));
    end
    step(0, '0);
    step(0, '0);
    chk("sb_drained", 64'(sk_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rle_index_seeker.md
RLE_INDEX_SEEKER -- requirements
Module: rle_index_seeker

Interface
REQ-001 Parameters SHALL be: SAMPLE_W, default 16, width of a stream word; INDEX_W, default 60, width of the decoded-sample index; WORD_W, default 32, width of the stream-word counter.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear
- sample  in  SAMPLE_W  compressed stream word
- sample_strobe  in  1  sample is valid this cycle
- index  out  INDEX_W  count of decoded samples
- word_count  out  WORD_W  count of consumed stream words
- seek_target  in  INDEX_W  decoded index to locate
- seek_start  in  1  arm seek (pulse)
- seek_busy  out  1  seek armed
- seek_done  out  1  one-cycle result pulse
- seek_miss  out  1  target was already passed
- seek_sample  out  SAMPLE_W  decoded value at target
- seek_word  out  WORD_W  word_count of the covering word
- state_out  out  2*SAMPLE_W+2  snapshot {run_value, last_sample, state}
- state_load  in  1  restore snapshot
- state_in  in  2*SAMPLE_W+2  snapshot to restore

Function
REQ-003 The decoder SHALL act only on cycles with sample_strobe=1; each such cycle word_count SHALL increment by 1, modulo 2^WORD_W.
REQ-004 The FSM SHALL have states FIRST(00), LIT(01) and RUN(10); code 11 SHALL behave as FIRST.
REQ-005 In FIRST: index+=1, last_sample<=sample, next state LIT.
REQ-006 In LIT: index+=1, last_sample<=sample; if sample==last_sample, then run_value<=sample and next state RUN; otherwise stay in LIT.
REQ-007 In RUN: index+=zero-extended sample; stay in RUN if sample is all-ones; otherwise next state FIRST. A count of 0 SHALL add 0. last_sample SHALL be unchanged.
REQ-008 index SHALL wrap modulo 2^INDEX_W with no flag.
REQ-009 Each strobed word SHALL cover the decoded span [index_old, index_new).
REQ-010 The decoded value SHALL be sample for FIRST/LIT words and run_value for RUN words.
REQ-011 seek_start SHALL latch seek_target, set seek_busy the next cycle, and clear any pending result.
REQ-012 While armed, including on a strobe in the same cycle as seek_start: if the current word's span contains the target, then on the next cycle seek_done=1 for one cycle, seek_busy=0, seek_sample=decoded value, and seek_word=word_count before increment.
REQ-013 If seek_start arrives with target<index (no strobe that cycle), then on the next cycle seek_done=1, seek_miss=1, seek_busy=0, and seek_sample/seek_word SHALL be unchanged.
REQ-014 seek_miss SHALL clear on the next seek_start.
REQ-015 seek_sample, seek_word and seek_miss SHALL hold until the next seek_start.
REQ-016 state_out SHALL be combinational from registers.
REQ-017 state_load SHALL overwrite run_value, last_sample and state from state_in, without changing index or word_count.
REQ-018 Priority SHALL be: clear > state_load > strobe decode.
REQ-019 A strobe coincident with state_load SHALL be dropped, with no count change.
REQ-020 clear SHALL zero index, word_count, state, seek_busy, seek_done and seek_miss.

Reset
REQ-021 On rst_n low: index=0, word_count=0, state=FIRST, seek_busy=0, seek_done=0, seek_miss=0, seek_sample=0, seek_word=0, seek_target=0, last_sample=0, run_value=0.
REQ-022 Reset asserted mid-seek SHALL abandon the seek; no seek_done SHALL be produced.

Structure
REQ-023 A shared package SHALL hold the FSM state encodings FIRST/LIT/RUN and the snapshot field offsets.
REQ-024 One sub-module, rle_span_check, SHALL perform the combinational test index_old<=target<index_new and select the decoded value; all other logic SHALL be in the top level.

Verification
REQ-025 Words A,B,C -> index=3, word_count=3, state LIT.
REQ-026 Words 5,5,0xFFFF,3 -> index 2, then 0x10001, then 0x10004; state FIRST; run_value=5.
REQ-027 Stream as REQ-026, seek_target=40000 armed before the first word -> seek_done one cycle after word 3; seek_sample=5; seek_word=2.
REQ-028 index=10, seek_target=4 -> seek_done and seek_miss next cycle; busy low.
REQ-029 Snapshot after 7,7 taken; clear; state_load; word 2 -> index=2 (run added); state FIRST.
REQ-030 rst_n pulsed during armed seek -> all outputs at REQ-021 values; no seek_done pulse afterwards.
